// File: rtl/game_of_life_pkg.sv
// rtl/game_of_life_pkg.sv - shared button indices, arbiter state type and helpers
//
// Purpose:
//   Common definitions for the movement-button front end that feeds the
//   per-cell setup-selection FSMs.
//
// Contents:
//   BTN_LEFT/BTN_RIGHT/BTN_DOWN/BTN_UP  bit positions inside the 4-bit button
//                                       vectors ({up, down, right, left}).
//   NUM_BUTTONS                         width of the button vectors.
//   arbState_t                          arbiter FSM state encoding.
//   maxOf                               elaboration-time max, used for counter sizing.
//   isSingle                            true when exactly one bit of a mask is set.
//   buttonIndex                         index of the set bit of a one-hot mask.

package game_of_life_pkg;

   localparam int BTN_LEFT    = 0;
   localparam int BTN_RIGHT   = 1;
   localparam int BTN_DOWN    = 2;
   localparam int BTN_UP      = 3;
   localparam int NUM_BUTTONS = 4;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_DELAY = 2'd1,
      REPEAT     = 2'd2,
      LOCKED     = 2'd3
   } arbState_t;

   function automatic int maxOf(input int a, input int b);
      maxOf = (a > b) ? a : b;
   endfunction

   // Clearing the lowest set bit leaves zero only for a one-hot mask.
   function automatic logic isSingle(input logic [NUM_BUTTONS-1:0] mask);
      isSingle = (mask != '0) && ((mask & (mask - 1'b1)) == '0);
   endfunction

   // Only meaningful for a one-hot mask; returns 0 for an empty mask.
   function automatic logic [1:0] buttonIndex(input logic [NUM_BUTTONS-1:0] mask);
      buttonIndex = 2'd0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         if (mask[i]) begin
            buttonIndex = 2'(i);
         end
      end
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - two-flop synchroniser plus consecutive-sample debounce for one key
//
// Purpose:
//   Brings one active-low board key into the clk domain and only accepts a
//   level change after DEBOUNCE_CYCLES consecutive synchronised samples that
//   disagree with the current stable level.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   rawN   in   unsynchronised key, active-low (0 = pressed)
//   held   out  debounced level, active-high (1 = pressed), registered

module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic rawN,
   output logic held
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             syncMeta;
   logic             syncOut;
   logic             stable;
   logic [CNT_W-1:0] cnt;

   // Synchroniser resets to 1 so a key held through reset release is seen as a
   // fresh press and must pass the full debounce window.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         syncMeta <= 1'b1;
         syncOut  <= 1'b1;
         stable   <= 1'b1;
         cnt      <= '0;
      end else begin
         syncMeta <= rawN;
         syncOut  <= syncMeta;
         if (syncOut == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            // This sample is the last of the required run of disagreeing samples.
            stable <= syncOut;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign held = ~stable;

endmodule

// File: rtl/movement_button_conditioner.sv
// rtl/movement_button_conditioner.sv - four debounced keys arbitrated into exclusive one-cycle movement pulses
//
// Purpose:
//   Turns the raw board keys into clean left/right/up/down pulses for the
//   setup-selection FSMs: one pulse per press, optional auto-repeat while a
//   single key stays held, chords lock out until everything is released, and
//   nothing is emitted while the game is running.
//
// Ports:
//   clk              in   system clock
//   reset            in   asynchronous active-low reset
//   rawButtons[3:0]  in   active-low unsynchronised keys {up, down, right, left}
//   startGameSwitch  in   1 = game running, movement pulses suppressed
//   leftButton       out  one-cycle pulse
//   rightButton      out  one-cycle pulse
//   upButton         out  one-cycle pulse
//   downButton       out  one-cycle pulse
//   heldButtons[3:0] out  debounced active-high held levels, same bit order

module movement_button_conditioner
   import game_of_life_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter bit REPEAT_EN       = 1'b1,
   parameter int REPEAT_DELAY    = 64,
   parameter int REPEAT_PERIOD   = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rawButtons,
   input  logic       startGameSwitch,
   output logic       leftButton,
   output logic       rightButton,
   output logic       upButton,
   output logic       downButton,
   output logic [3:0] heldButtons
);

   localparam int RCNT_W = $clog2(maxOf(REPEAT_DELAY, REPEAT_PERIOD) + 1);
   localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
   localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

   logic [NUM_BUTTONS-1:0] heldVec;

   arbState_t              state;
   arbState_t              stateNext;
   logic [RCNT_W-1:0]      rcnt;
   logic [RCNT_W-1:0]      rcntNext;
   logic [1:0]             latched;
   logic [1:0]             latchedNext;
   logic [NUM_BUTTONS-1:0] pulseNext;
   logic [NUM_BUTTONS-1:0] pulseReg;

   logic [NUM_BUTTONS-1:0] latchedMask;
   logic                   leaveHold;

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : gDebounce
      button_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) uDebounce (
         .clk  (clk),
         .reset(reset),
         .rawN (rawButtons[i]),
         .held (heldVec[i])
      );
   end

   assign latchedMask = NUM_BUTTONS'(4'b0001 << latched);

   // A hold episode ends as soon as the game starts or the held set is
   // anything other than the key that opened the episode.
   assign leaveHold = startGameSwitch || (heldVec != latchedMask);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         rcnt     <= '0;
         latched  <= 2'd0;
         pulseReg <= '0;
      end else begin
         state    <= stateNext;
         rcnt     <= rcntNext;
         latched  <= latchedNext;
         pulseReg <= pulseNext;
      end
   end

   always_comb begin
      stateNext   = state;
      rcntNext    = rcnt;
      latchedNext = latched;
      pulseNext   = '0;
      case (state)
         IDLE: begin
            if (startGameSwitch) begin
               stateNext = LOCKED;
            end else if (isSingle(heldVec)) begin
               pulseNext   = heldVec;
               latchedNext = buttonIndex(heldVec);
               rcntNext    = '0;
               stateNext   = WAIT_DELAY;
            end else if (heldVec != '0) begin
               // Keys that debounce on the same edge are treated as a chord.
               stateNext = LOCKED;
            end
         end
         WAIT_DELAY: begin
            if (leaveHold) begin
               stateNext = (heldVec == '0) ? IDLE : LOCKED;
            end else if (REPEAT_EN && (rcnt == DELAY_LAST)) begin
               pulseNext = latchedMask;
               rcntNext  = '0;
               stateNext = REPEAT;
            end else if (rcnt != DELAY_LAST) begin
               // Stops at DELAY_LAST when repeat is disabled, so it never wraps.
               rcntNext = rcnt + 1'b1;
            end
         end
         REPEAT: begin
            if (leaveHold) begin
               stateNext = (heldVec == '0) ? IDLE : LOCKED;
            end else if (rcnt == PERIOD_LAST) begin
               pulseNext = latchedMask;
               rcntNext  = '0;
            end else begin
               rcntNext = rcnt + 1'b1;
            end
         end
         LOCKED: begin
            // Requires a full release so a key held across a game stop or a
            // chord has to be re-pressed before it moves anything.
            if ((heldVec == '0) && !startGameSwitch) begin
               stateNext = IDLE;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   assign leftButton  = pulseReg[BTN_LEFT];
   assign rightButton = pulseReg[BTN_RIGHT];
   assign downButton  = pulseReg[BTN_DOWN];
   assign upButton    = pulseReg[BTN_UP];
   assign heldButtons = heldVec;

endmodule

// File: tb/tb_movement_button_conditioner.sv
// tb/tb_movement_button_conditioner.sv - randomized self-checking bench with a behavioural key model

module tb_movement_button_conditioner;

   localparam int D       = 4;
   localparam bit REP_EN  = 1'b1;
   localparam int RDELAY  = 8;
   localparam int RPERIOD = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] rawButtons = 4'hF;
   logic       startGameSwitch = 1'b0;
   logic       leftButton;
   logic       rightButton;
   logic       upButton;
   logic       downButton;
   logic [3:0] heldButtons;
   logic [3:0] pulses;

   int checkCount = 0;
   int errorCount = 0;
   int pulseSeen  = 0;

   // Behavioural reference state.
   logic [3:0] rawQ[$];
   logic [3:0] sampHist[$];
   logic [3:0] heldExp;
   logic [3:0] pulseExp;
   logic [3:0] ownerMask;
   bit         blocked;
   int         since;
   int         edgeNo;

   always #5 clk = ~clk;

   movement_button_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_EN      (REP_EN),
      .REPEAT_DELAY   (RDELAY),
      .REPEAT_PERIOD  (RPERIOD)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .rawButtons     (rawButtons),
      .startGameSwitch(startGameSwitch),
      .leftButton     (leftButton),
      .rightButton    (rightButton),
      .upButton       (upButton),
      .downButton     (downButton),
      .heldButtons    (heldButtons)
   );

   task automatic checkValue(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed != expected) begin
         errorCount++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      rawQ.delete();
      rawQ.push_back(4'hF);
      rawQ.push_back(4'hF);
      sampHist.delete();
      heldExp   = '0;
      pulseExp  = '0;
      ownerMask = '0;
      blocked   = 1'b0;
      since     = 0;
      edgeNo    = 0;
   endtask

   // One active edge: the arbiter decision uses held/start as they were before
   // the edge; a key level flips once its last D synchronised samples all disagree.
   task automatic modelStep(input logic [3:0] raw, input logic start);
      logic [3:0] samp;
      int         age;
      bit         allDiffer;
      pulseExp = '0;
      if (blocked) begin
         if (heldExp == 4'h0 && !start) blocked = 1'b0;
      end else if (ownerMask != 4'h0) begin
         if (start || heldExp != ownerMask) begin
            ownerMask = '0;
            blocked   = (heldExp != 4'h0);
         end else begin
            age = edgeNo - since;
            if (REP_EN && (age == RDELAY || (age > RDELAY && (age - RDELAY) % RPERIOD == 0)))
               pulseExp = ownerMask;
         end
      end else begin
         if (start) blocked = 1'b1;
         else if ($countones(heldExp) == 1) begin
            pulseExp  = heldExp;
            ownerMask = heldExp;
            since     = edgeNo;
         end else if (heldExp != 4'h0) blocked = 1'b1;
      end

      samp = rawQ.pop_front();
      rawQ.push_back(raw);
      sampHist.push_back(samp);
      if (sampHist.size() > D) void'(sampHist.pop_front());
      if (sampHist.size() == D) begin
         for (int b = 0; b < 4; b++) begin
            allDiffer = 1'b1;
            foreach (sampHist[k]) if (sampHist[k][b] != heldExp[b]) allDiffer = 1'b0;
            if (allDiffer) heldExp[b] = ~heldExp[b];
         end
      end
      edgeNo++;
   endtask

   task automatic runCycle();
      @(posedge clk);
      if (reset) modelStep(rawButtons, startGameSwitch);
      @(negedge clk);
      pulses = {upButton, downButton, rightButton, leftButton};
      checkValue("held", int'(heldButtons), int'(heldExp));
      checkValue("pulse", int'(pulses), int'(pulseExp));
      checkValue("exclusive", int'($countones(pulses) <= 1), 1);
      pulseSeen += $countones(pulses);
   endtask

   task automatic hold(input logic [3:0] raw, input int n);
      rawButtons = raw;
      repeat (n) runCycle();
   endtask

   initial begin
      logic [3:0] m;
      int         sel;
      modelReset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      pulses = {upButton, downButton, rightButton, leftButton};
      checkValue("rstHeld", int'(heldButtons), 0);
      checkValue("rstPulse", int'(pulses), 0);
      reset = 1'b1;

      // single press: one pulse, released before the repeat point
      pulseSeen = 0;
      hold(4'hE, 6);
      hold(4'hF, 20);
      checkValue("singleCount", pulseSeen, 1);

      // bounce on right never reaches D samples
      pulseSeen = 0;
      repeat (4) begin
         hold(4'hD, 3);
         hold(4'hF, 1);
      end
      hold(4'hF, 4);
      checkValue("bounceCount", pulseSeen, 0);
      pulseSeen = 0;
      hold(4'hD, 8);
      hold(4'hF, 20);
      checkValue("rightCount", pulseSeen, 1);

      // auto-repeat on up: pulses at 7,15,19,23,27,31,35
      pulseSeen = 0;
      hold(4'h7, 30);
      hold(4'hF, 20);
      checkValue("repeatCount", pulseSeen, 7);

      // chord lockout
      hold(4'hB, 10);
      hold(4'hA, 10);
      hold(4'hB, 10);
      hold(4'hF, 15);
      hold(4'hE, 8);
      hold(4'hF, 15);

      // game running suppresses pulses, held still tracks
      startGameSwitch = 1'b1;
      pulseSeen = 0;
      for (int b = 0; b < 4; b++) begin
         m = 4'b0001 << b;
         hold(~m, 20);
         hold(4'hF, 10);
      end
      hold(4'hD, 10);
      startGameSwitch = 1'b0;
      hold(4'hD, 10);
      checkValue("suppressCount", pulseSeen, 0);
      hold(4'hF, 15);
      hold(4'hD, 8);
      hold(4'hF, 15);

      // asynchronous reset mid-repeat
      hold(4'h7, 20);
      #2 reset = 1'b0;
      #1;
      pulses = {upButton, downButton, rightButton, leftButton};
      checkValue("asyncHeld", int'(heldButtons), 0);
      checkValue("asyncPulse", int'(pulses), 0);
      modelReset();
      repeat (2) runCycle();
      reset = 1'b1;
      pulseSeen = 0;
      hold(4'h7, 6);
      checkValue("rstEarly", pulseSeen, 0);
      hold(4'h7, 1);
      checkValue("rstFirst", pulseSeen, 1);
      hold(4'h7, 10);
      hold(4'hF, 20);

      // randomized presses, chords, bounces and game toggles
      repeat (60) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 6) begin
            m = 4'b0001;
            m = m << $urandom_range(0, 3);
         end else if (sel < 8) begin
            m = 4'($urandom_range(0, 15));
         end else begin
            m = 4'h0;
         end
         startGameSwitch = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 3) == 0) begin
            repeat (3) begin
               hold(~m, int'($urandom_range(1, 3)));
               hold(4'hF, 1);
            end
         end
         hold(~m, int'($urandom_range(1, 40)));
      end
      startGameSwitch = 1'b0;
      hold(4'hF, 20);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
